// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction prefetch stage ahead of the IF/ID register.
// Issues in-order word fetches to a variable-latency instruction memory (one
// outstanding request), buffers {instr, pc+4} in a DEPTH-entry FIFO and hands
// the head to IF/ID under valid/ready. A redirect flushes the FIFO, discards
// any in-flight response and restarts fetch at the new target.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect, redirect_pc    flush + new fetch target (bits [1:0] forced to 0)
//   imem_req, imem_addr      fetch request / word address
//   imem_valid, imem_rdata   response for the outstanding request
//   out_valid, out_instr,    head entry to IF/ID (instr/pc_incr are 0 when
//   out_pc_incr, out_ready   out_valid=0); pop on out_valid & out_ready
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// IF/ID in the cycle it arrives when the FIFO is empty (0-cycle latency).
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_incr,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [31:0]    req_addr;
  logic [31:0]    q_instr [DEPTH];
  logic [31:0]    q_pc    [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;

  logic           fifo_valid, bypass, fifo_pop, push, can_issue;
  logic [AW+1:0]  occ;

  assign fifo_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = !rst && !redirect && (state == WAIT) && imem_valid && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !rst && (fifo_valid || bypass);

  always_comb begin
    out_instr   = 32'd0;
    out_pc_incr = 32'd0;
    if (out_valid) begin
      if (fifo_valid) begin
        out_instr   = q_instr[rd_ptr];
        out_pc_incr = q_pc[rd_ptr];
      end else begin
        out_instr   = imem_rdata;
        out_pc_incr = req_addr + 32'd4;
      end
    end
  end

  // A bypassed word taken by IF/ID never enters the FIFO.
  assign fifo_pop = fifo_valid && out_ready && !redirect && !rst;
  assign push     = (state == WAIT) && imem_valid && !redirect && !(bypass && out_ready);

  // Occupancy after this cycle's pop and push; pop is counted first so a full
  // FIFO being drained can still accept the arriving word and issue again.
  assign occ       = {1'b0, count} + (AW+2)'(push) - (AW+2)'(fifo_pop);
  assign can_issue = (state == IDLE) || imem_valid;
  assign imem_req  = !rst && !redirect && can_issue && (occ < DEPTH_W);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= 32'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      // An in-flight request not yet answered must have its word discarded.
      state    <= (state != IDLE && !imem_valid) ? DROP : IDLE;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= req_addr + 32'd4;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(fifo_pop);
      if (imem_req) begin
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
        state    <= WAIT;
      end else if (state != IDLE && imem_valid) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, redirect, imem_valid, out_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_instr, out_pc_incr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  int          mem_lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc_incr(out_pc_incr), .out_ready(out_ready)
  );

  // Memory contents: a tag byte over the low address bits, easy to read by hand.
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(logic [31:0] a);
    exp_t e;
    e.instr = instr_of(a);
    e.pc    = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(logic [31:0] a);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) begin ok = 1; break; end
    end
    chk("wait_req", {31'd0, ok}, 32'd1);
  endtask

  // Consume until every expected entry is seen, then stop accepting.
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    #1 out_ready = 1'b0;
    chk("drain", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_redirect(logic [31:0] a);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = a;
    @(negedge clk);
    chk("req_in_redirect", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  // Memory model: fixed latency mem_lat, one outstanding request.
  initial begin
    imem_valid = 1'b0; imem_rdata = 32'd0; pend = 0; pend_cnt = 0; pend_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (imem_req) begin pend = 1; pend_addr = imem_addr; pend_cnt = mem_lat; end
      @(posedge clk); #1;
      imem_valid = 1'b0; imem_rdata = 32'd0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_valid = 1'b1; imem_rdata = instr_of(pend_addr); pend = 0;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted head is compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !redirect && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pop: got instr %h pc_incr %h, expected none", out_instr, out_pc_incr);
        end else begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_pc_incr", out_pc_incr, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1; mem_lat = 1;

    // Reset state and streaming with a 1-cycle memory.
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc_incr", out_pc_incr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_req", {31'd0, imem_req}, 32'd1);
      chk("stream_addr", imem_addr, 32'(i * 4));
    end
    drain();

    // Backpressure: fill to DEPTH, fetch stops, drains in order, resumes at 0x10.
    do_redirect(32'h0);
    repeat (10) @(negedge clk);
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    drain();

    // Redirect while a 3-cycle fetch of 0x8 is in flight.
    mem_lat = 3;
    do_redirect(32'h0);
    wait_req(32'h8);
    do_redirect(32'h0000_0103);
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    wait_req(32'h100);
    push_exp(32'h100);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Redirect coinciding with imem_valid and out_ready: no push, no pop.
    do_redirect(32'h200);
    wait_req(32'h204);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
    @(negedge clk);
    chk("redir_valid_req", {31'd0, imem_req}, 32'd0);
    chk("redir_head_present", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    redirect = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("redir_valid_empty", {31'd0, out_valid}, 32'd0);
    chk("redir_valid_next_req", {31'd0, imem_req}, 32'd1);
    chk("redir_valid_next_addr", imem_addr, 32'h300);
    push_exp(32'h300);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Fetch address wrap at the top of the address space.
    mem_lat = 1;
    do_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Response-to-IF/ID latency with an empty queue (0 with bypass, else 1).
    mem_lat = 2;
    do_redirect(32'h400);
    push_exp(32'h400);
    push_exp(32'h404);
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_req_addr", imem_addr, 32'h400);
    @(negedge clk);
    chk("lat_before", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    chk("lat_resp_cycle", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("lat_after", {31'd0, out_valid}, 32'd0);
`else
    chk("lat_resp_cycle", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_after", {31'd0, out_valid}, 32'd1);
`endif
    drain();

    // Reset in the middle of operation.
    mem_lat = 1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_first_req", {31'd0, imem_req}, 32'd1);
    chk("midrst_first_addr", imem_addr, 32'h0);

    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction prefetch stage sitting directly upstream of the IF/ID pipeline register in the pipelined MIPS core. It issues in-order fetch requests to a variable-latency instruction memory, buffers returned words with their incremented PC in a small FIFO, and presents one instruction per cycle to IF/ID under a valid/ready handshake. A branch/jump redirect from decode flushes the queue, discards any in-flight response and restarts fetch at the new target.

## Interface
- DEPTH, 4: queue entries, power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.
- imem_req  out  1  request issued this cycle.
- imem_addr  out  32  word-aligned fetch address, valid while imem_req=1.
- imem_valid  in  1  response for the single outstanding request.
- imem_rdata  in  32  instruction word, valid while imem_valid=1.
- out_valid  out  1  head entry available to IF/ID.
- out_instr  out  32  head instruction; 32'd0 (nop) when out_valid=0.
- out_pc_incr  out  32  head fetch address + 4; 32'd0 when out_valid=0.
- out_ready  in  1  IF/ID accepts head this cycle (pop when out_valid & out_ready).

## Operation
- Registers: fetch_pc (next address to request), FIFO array + rd/wr pointers + count (0..DEPTH), req_addr (address of in-flight request), FSM state.
- FSM states: IDLE (nothing in flight), WAIT (one request in flight, response kept), DROP (one request in flight, response discarded).
- At most one outstanding request; memory returns responses in order, ≥1 cycle after request.
- Issue condition: imem_req = !rst & !redirect & (count_next_after_pop + inflight_kept) < DEPTH, where the FSM is IDLE, or WAIT/DROP with imem_valid=1 this cycle. imem_addr = fetch_pc. On issue: req_addr←fetch_pc, fetch_pc←fetch_pc+4 (wraps modulo 2^32), state→WAIT.
- IDLE, no issue: stay IDLE.
- WAIT & imem_valid: push {imem_rdata, req_addr+4}; issue back-to-back if condition holds, else →IDLE.
- DROP & imem_valid: discard word; issue if condition holds (→WAIT), else →IDLE.
- WAIT/DROP & !imem_valid: hold state; no request.
- redirect (highest priority): FIFO cleared (count←0, pointers←0), any pop ignored, fetch_pc←{redirect_pc[31:2],2'b00}, no request this cycle. State: WAIT or DROP without imem_valid →DROP; with imem_valid same cycle →IDLE (response consumed and discarded); IDLE→IDLE.
- Push and pop in the same cycle: count unchanged; legal when full because pop is counted before issue.
- FIFO never overflows: issue check reserves a slot for the in-flight word.

## Timing
- Reset: fetch_pc=RESET_PC, count=0, pointers=0, state=IDLE, imem_req=0 during rst, out_valid=0, out_instr=0, out_pc_incr=0.
- First request: cycle after rst deasserts, imem_addr=RESET_PC.
- Response at cycle M (FIFO empty) → out_valid=1 at M+1.
- Redirect at cycle N (state IDLE after) → imem_req with new target at N+1.
- Sustained throughput with 1-cycle memory: one instruction per cycle after initial fill.
- rst mid-operation overrides everything; an in-flight response arriving after reset is not tracked (memory is reset with the core).

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty, imem_valid=1 in WAIT and no redirect, out_valid/out_instr/out_pc_incr drive the response combinationally in cycle M; if out_ready=1 that cycle the word is not written to the FIFO. Latency response→IF/ID drops to 0 cycles.
- Not defined: all outputs come from the FIFO head only; latency 1 cycle as above.

## Test plan
- Reset then 1-cycle memory returning addr-based words, out_ready=1 → imem_addr 0,4,8,… on consecutive cycles; out_instr matches, out_pc_incr 4,8,12,…
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered, imem_req stays 0 once full; release → 4 entries drain in order, fetch resumes at 0x10.
- Redirect to 0x0000_0103 while a 3-cycle request to 0x8 is in flight → FIFO empty next cycle, 0x8 response discarded, next imem_addr=0x100, out_pc_incr=0x104.
- Redirect in same cycle as imem_valid and out_ready=1 → no push, no pop, state IDLE, next request at target.
- fetch_pc=0xFFFF_FFFC → following request at 0x0000_0000; out_pc_incr for that entry 0x0000_0000.
- With FETCH_BYPASS_EN, empty queue, response in cycle M, out_ready=1 → out_valid=1 in cycle M, count stays 0.
